// File: rtl/dff_response_checker_if.sv
// Stimulus/observation and verdict bundle between a flop testbench and the response checker.
interface dff_response_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_checks;
    logic             obs_data;
    logic             obs_rst;
    logic             obs_q;
    logic             busy;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] toggle_count;
    logic             done;
    logic             fail;

    modport master (
        output start, num_checks, obs_data, obs_rst, obs_q,
        input  busy, mismatch, err_count, toggle_count, done, fail
    );

    modport slave (
        input  start, num_checks, obs_data, obs_rst, obs_q,
        output busy, mismatch, err_count, toggle_count, done, fail
    );
endinterface

// File: rtl/dff_response_checker.sv
// Response monitor for an async-reset D flop: one-cycle-delayed reference model compared
// against the observed q over a counted window, with error/toggle counters and a verdict.
module dff_response_checker #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ERR_LIMIT = 1
) (
    input logic                 clk,
    input logic                 reset,
    dff_response_checker_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StWarmup, StCheck, StDone, StFail} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] ErrLim = CNT_W'(ERR_LIMIT);

    state_e           state_q, state_d;
    logic             exp_q, exp_d;
    logic             prev_q, prev_d;
    logic             mm_q, mm_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] tog_q, tog_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q       <= 1'b0;
            prev_q      <= 1'b0;
            mm_q        <= 1'b0;
            remaining_q <= '0;
            err_q       <= '0;
            tog_q       <= '0;
        end else begin
            exp_q       <= exp_d;
            prev_q      <= prev_d;
            mm_q        <= mm_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            tog_q       <= tog_d;
        end
    end

    // Datapath: the reference flop tracks the stimulus in every state.
    always_comb begin
        exp_d       = bus.obs_rst ? 1'b0 : bus.obs_data;
        prev_d      = prev_q;
        mm_d        = 1'b0;
        remaining_d = remaining_q;
        err_d       = err_q;
        tog_d       = tog_q;
        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.start) begin
                    remaining_d = bus.num_checks;
                    err_d       = '0;
                    tog_d       = '0;
                end
            end
            StWarmup: begin
                prev_d = bus.obs_q;
            end
            StCheck: begin
                if (bus.obs_q != exp_q) begin
                    mm_d = 1'b1;
                    if (err_q != CntMax) err_d = err_q + CntOne;
                end
                if ((bus.obs_q != prev_q) && (tog_q != CntMax)) tog_d = tog_q + CntOne;
                prev_d = bus.obs_q;
                // CHECK is only entered with a nonzero count, so this never wraps.
                remaining_d = remaining_q - CntOne;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StFail: if (bus.start) state_d = StWarmup;
            StWarmup: state_d = (remaining_q == '0) ? StDone : StCheck;
            StCheck: begin
                if (err_d >= ErrLim) state_d = StFail;
                else if (remaining_d == '0) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.fail = 1'b0;
        unique case (state_q)
            StWarmup, StCheck: bus.busy = 1'b1;
            StDone:            bus.done = 1'b1;
            StFail:            bus.fail = 1'b1;
            default: ;
        endcase
    end

    assign bus.mismatch     = mm_q;
    assign bus.err_count    = err_q;
    assign bus.toggle_count = tog_q;
endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: two instances (error limit 1 and 3) share one stimulus stream.
module tb_dff_response_checker;
    localparam int MaxL = 64;

    logic clk;
    logic reset;

    dff_response_checker_if #(.CNT_W(8)) bus1 ();
    dff_response_checker_if #(.CNT_W(8)) bus3 ();

    dff_response_checker #(.CNT_W(8), .ERR_LIMIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dff_response_checker #(.CNT_W(8), .ERR_LIMIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-window stimulus, indexed by cycle relative to the start pulse.
    logic d_a [MaxL];
    logic r_a [MaxL];
    logic q_a [MaxL];
    logic s_a [MaxL];

    // Expected outputs per instance (0: limit 1, 1: limit 3) per cycle.
    logic m_busy [2][MaxL];
    logic m_mm   [2][MaxL];
    logic m_done [2][MaxL];
    logic m_fail [2][MaxL];
    int   m_err  [2][MaxL];
    int   m_tog  [2][MaxL];

    typedef struct {
        int n; int kind; int c1; int c2;
        int err1; int tog1; bit done1; bit fail1;
        int err3; int tog3; bit done3; bit fail3;
    } row_t;
    row_t rows [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] nc, input logic d, input logic r,
                         input logic q);
        bus1.start = st; bus1.num_checks = nc; bus1.obs_data = d; bus1.obs_rst = r;
        bus1.obs_q = q;
        bus3.start = st; bus3.num_checks = nc; bus3.obs_data = d; bus3.obs_rst = r;
        bus3.obs_q = q;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " L1 busy"}, 32'(bus1.busy), 0);
        chk({tag, " L1 mismatch"}, 32'(bus1.mismatch), 0);
        chk({tag, " L1 err"}, 32'(bus1.err_count), 0);
        chk({tag, " L1 tog"}, 32'(bus1.toggle_count), 0);
        chk({tag, " L1 done"}, 32'(bus1.done), 0);
        chk({tag, " L1 fail"}, 32'(bus1.fail), 0);
        chk({tag, " L3 busy"}, 32'(bus3.busy), 0);
        chk({tag, " L3 mismatch"}, 32'(bus3.mismatch), 0);
        chk({tag, " L3 err"}, 32'(bus3.err_count), 0);
        chk({tag, " L3 tog"}, 32'(bus3.toggle_count), 0);
        chk({tag, " L3 done"}, 32'(bus3.done), 0);
        chk({tag, " L3 fail"}, 32'(bus3.fail), 0);
    endtask

    function automatic logic ref_q(input int j);
        return r_a[j] ? 1'b0 : d_a[j];
    endfunction

    task automatic ideal_q(input int len);
        q_a[0] = 1'b0;
        for (int k = 1; k < len; k++) q_a[k] = ref_q(k - 1);
    endtask

    // Window outcome from the rules: compares at edges 2..n+1, stop at the lim-th mismatch.
    task automatic build_model(input int w, input int lim, input int n, input int len);
        int mm_e[$];
        int tg_e[$];
        int end_e;
        bit failed;
        int ce;
        int ct;
        end_e  = (n == 0) ? 1 : n + 1;
        failed = 1'b0;
        for (int e = 2; e <= n + 1; e++) begin
            if (q_a[e] != ref_q(e - 1)) mm_e.push_back(e);
            if (q_a[e] != q_a[e - 1]) tg_e.push_back(e);
            if (mm_e.size() == lim) begin
                end_e  = e;
                failed = 1'b1;
                break;
            end
        end
        for (int k = 1; k < len; k++) begin
            ce = 0;
            ct = 0;
            m_mm[w][k] = 1'b0;
            foreach (mm_e[i]) begin
                if (mm_e[i] < k) ce++;
                if (mm_e[i] == k - 1) m_mm[w][k] = 1'b1;
            end
            foreach (tg_e[i]) if (tg_e[i] < k) ct++;
            m_err[w][k]  = (ce > 255) ? 255 : ce;
            m_tog[w][k]  = (ct > 255) ? 255 : ct;
            m_busy[w][k] = (k <= end_e);
            m_done[w][k] = !failed && (k > end_e);
            m_fail[w][k] = failed && (k > end_e);
        end
    endtask

    task automatic check_model(input string tag, input int k);
        string p1;
        string p3;
        p1 = $sformatf("%s c%0d L1", tag, k);
        p3 = $sformatf("%s c%0d L3", tag, k);
        chk({p1, " busy"}, 32'(bus1.busy), 32'(m_busy[0][k]));
        chk({p1, " mismatch"}, 32'(bus1.mismatch), 32'(m_mm[0][k]));
        chk({p1, " err"}, 32'(bus1.err_count), m_err[0][k]);
        chk({p1, " tog"}, 32'(bus1.toggle_count), m_tog[0][k]);
        chk({p1, " done"}, 32'(bus1.done), 32'(m_done[0][k]));
        chk({p1, " fail"}, 32'(bus1.fail), 32'(m_fail[0][k]));
        chk({p3, " busy"}, 32'(bus3.busy), 32'(m_busy[1][k]));
        chk({p3, " mismatch"}, 32'(bus3.mismatch), 32'(m_mm[1][k]));
        chk({p3, " err"}, 32'(bus3.err_count), m_err[1][k]);
        chk({p3, " tog"}, 32'(bus3.toggle_count), m_tog[1][k]);
        chk({p3, " done"}, 32'(bus3.done), 32'(m_done[1][k]));
        chk({p3, " fail"}, 32'(bus3.fail), 32'(m_fail[1][k]));
    endtask

    // Called at posedge+1; returns at posedge+1. abort_k >= 0 pulls checker reset in that cycle.
    task automatic run_window(input string tag, input int n, input int abort_k);
        int len;
        logic [7:0] nc;
        len = n + 5;
        build_model(0, 1, n, len);
        build_model(1, 3, n, len);
        for (int k = 0; k < len; k++) begin
            nc = (k == 0) ? n[7:0] : 8'hA5;
            drive(s_a[k], nc, d_a[k], r_a[k], q_a[k]);
            @(negedge clk);
            if (k >= 1) check_model(tag, k);
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                check_zero({tag, " async reset"});
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_pattern(input int len);
        for (int k = 0; k < MaxL; k++) begin
            d_a[k] = ((k / 5) % 2) == 1;
            r_a[k] = 1'b0;
            s_a[k] = (k == 0);
        end
        ideal_q(len);
    endtask

    initial begin
        int len;
        int n;
        rows[0] = '{40, 0, 0, 0,  0, 8, 1'b1, 1'b0,  0, 8, 1'b1, 1'b0};
        rows[1] = '{40, 1, 10, 0, 1, 1, 1'b0, 1'b1,  1, 8, 1'b1, 1'b0};
        rows[2] = '{20, 2, 5, 9,  1, 0, 1'b0, 1'b1,  2, 4, 1'b1, 1'b0};
        rows[3] = '{20, 3, 0, 0,  0, 4, 1'b1, 1'b0,  0, 4, 1'b1, 1'b0};
        rows[4] = '{20, 4, 0, 0,  1, 1, 1'b0, 1'b1,  2, 4, 1'b1, 1'b0};

        reset = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        #3;
        check_zero("in reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_zero($sformatf("idle c%0d", i));
        end
        @(posedge clk);
        #1;

        foreach (rows[i]) begin
            len = rows[i].n + 5;
            fill_pattern(len);
            if (rows[i].kind >= 3) begin
                for (int k = 8; k <= 12; k++) r_a[k] = 1'b1;
                ideal_q(len);
            end
            if (rows[i].kind == 4) for (int k = 1; k < len; k++) q_a[k] = d_a[k - 1];
            if (rows[i].kind == 1) q_a[rows[i].c1 + 1] = 1'b1;
            if (rows[i].kind == 2) begin
                q_a[rows[i].c1 + 1] = ~q_a[rows[i].c1 + 1];
                q_a[rows[i].c2 + 1] = ~q_a[rows[i].c2 + 1];
            end
            run_window($sformatf("row%0d", i), rows[i].n, -1);
            chk($sformatf("row%0d final L1 err", i), 32'(bus1.err_count), rows[i].err1);
            chk($sformatf("row%0d final L1 tog", i), 32'(bus1.toggle_count), rows[i].tog1);
            chk($sformatf("row%0d final L1 done", i), 32'(bus1.done), 32'(rows[i].done1));
            chk($sformatf("row%0d final L1 fail", i), 32'(bus1.fail), 32'(rows[i].fail1));
            chk($sformatf("row%0d final L3 err", i), 32'(bus3.err_count), rows[i].err3);
            chk($sformatf("row%0d final L3 tog", i), 32'(bus3.toggle_count), rows[i].tog3);
            chk($sformatf("row%0d final L3 done", i), 32'(bus3.done), 32'(rows[i].done3));
            chk($sformatf("row%0d final L3 fail", i), 32'(bus3.fail), 32'(rows[i].fail3));
        end

        // Checker reset just after compare 15 of 30, with one earlier mismatch on record.
        fill_pattern(35);
        q_a[4] = ~q_a[4];
        run_window("abort", 30, 17);
        @(negedge clk);
        check_zero("after abort");
        @(posedge clk);
        #1;

        // Zero-length window, with a start during warm-up that must be ignored.
        fill_pattern(5);
        s_a[1] = 1'b1;
        run_window("zero", 0, -1);
        chk("zero final L3 err", 32'(bus3.err_count), 0);
        chk("zero final L3 done", 32'(bus3.done), 1);

        // Starts while checking must not restart or reload the count.
        fill_pattern(10);
        s_a[2] = 1'b1;
        s_a[4] = 1'b1;
        run_window("busy start", 5, -1);

        for (int w = 0; w < 8; w++) begin
            n = $urandom_range(0, 30);
            len = n + 5;
            for (int k = 0; k < MaxL; k++) begin
                d_a[k] = 1'($urandom_range(0, 1));
                r_a[k] = ($urandom_range(0, 5) == 0);
                s_a[k] = (k == 0);
            end
            ideal_q(len);
            for (int k = 1; k < len; k++) if ($urandom_range(0, 11) == 0) q_a[k] = ~q_a[k];
            run_window($sformatf("rand%0d", w), n, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
